// File: rtl/alu_ops_pkg.sv
// Opcode encodings and widths shared by the ALU pipeline and its operator datapath.
// The opcode space is fully populated, so every 4-bit code is a legal operator.
package alu_ops_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_LAND = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_LOR  = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_LTU  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_EQ   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_RAND = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_RXOR = 4'd12;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 4'd13;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 4'd14;
  localparam logic [OPCODE_W-1:0] OP_CAT  = 4'd15;

endpackage

// File: rtl/operator_compute.sv
// Combinational operator datapath: one opcode-selected result plus ADD carry / SUB borrow.
// Latency: zero cycles. Backpressure: none, because this block holds no state.
module operator_compute
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    result,
  output logic                carry
);

  localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH+1)'(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           shift_oob;

  assign sum       = {1'b0, a} + {1'b0, b};
  // For unsigned operands, the top bit of the widened difference is the borrow (a < b).
  assign diff      = {1'b0, a} - {1'b0, b};
  assign shift_oob = {1'b0, b} >= SHIFT_LIMIT;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD:  begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
      OP_SUB:  begin result = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
      OP_LAND: result[0] = (a != '0) && (b != '0);
      OP_LOR:  result[0] = (a != '0) || (b != '0);
      OP_LTU:  result[0] = a < b;
      OP_EQ:   result[0] = a == b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_RAND: result[0] = &a;
      OP_ROR:  result[0] = |a;
      OP_RXOR: result[0] = ^a;
      OP_SHL:  result = shift_oob ? '0 : (a << b);
      OP_SHR:  result = shift_oob ? '0 : (a >> b);
      OP_CAT:  result = {a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
    endcase
  end

endmodule

// File: rtl/operator_pipeline_alu.sv
// Two-stage valid/ready ALU. An input transfer produces out_valid 2 cycles later, at up to 1 op/cycle.
// Backpressure: out_valid=1 with out_ready=0 holds stage 2, and in_ready drops once stage 1 is also full.
module operator_pipeline_alu
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                carry,
  output logic                zero
);

  logic                s1_valid;
  logic [OPCODE_W-1:0] s1_opcode;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;

  logic [WIDTH-1:0]    comp_result;
  logic                comp_carry;
  logic                s1_load;
  logic                s2_load;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign s1_load  = !s1_valid || s2_load;
  // This path is combinational from out_ready, so a full pipeline can accept and drain in one cycle.
  assign in_ready = s1_load;

  operator_compute #(
    .WIDTH (WIDTH)
  ) u_compute (
    .opcode (s1_opcode),
    .a      (s1_a),
    .b      (s1_b),
    .result (comp_result),
    .carry  (comp_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_opcode <= opcode;
        s1_a      <= operand_a;
        s1_b      <= operand_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= comp_result;
      carry     <= comp_carry;
      zero      <= (comp_result == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
